// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave front-end.
// Holds the FSM state encoding, the default device address and the ACK/NACK line levels.
package i2c_pkg;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;
    localparam logic       ACK                = 1'b0;
    localparam logic       NACK               = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_ADDR,
        ST_ACK_REG,
        ST_WR_LSB,
        ST_ACK_LSB,
        ST_WR_MSB,
        ST_ACK_MSB,
        ST_RD_LSB,
        ST_MACK_LSB,
        ST_RD_MSB,
        ST_MACK_MSB,
        ST_WAIT_STOP
    } i2c_state_t;

    // States in which the slave shifts a byte in from the master.
    function automatic logic is_rx_state(input i2c_state_t s);
        return (s == ST_DEV_ADDR) || (s == ST_REG_ADDR) ||
               (s == ST_WR_LSB)   || (s == ST_WR_MSB);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the CLK domain through 2-flop synchronizers and
// derives SCL edges plus START/STOP bus conditions from the synchronized lines.
module i2c_bus_sync (
    input  logic CLK,
    input  logic Reset,
    input  logic SCL,
    input  logic iSDA,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic r_scl_meta;
    logic r_scl_sync;
    logic r_scl_prev;
    logic r_sda_meta;
    logic r_sda_sync;
    logic r_sda_prev;

    // NOTE: these flops reset to 1 (idle bus level) so leaving reset never
    // fabricates an edge, START or STOP.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= SCL;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= iSDA;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign scl_rise  =  r_scl_sync & ~r_scl_prev;
    assign scl_fall  = ~r_scl_sync &  r_scl_prev;
    assign start_det =  r_scl_sync &  r_scl_prev &  r_sda_prev & ~r_sda_sync;
    assign stop_det  =  r_scl_sync &  r_scl_prev & ~r_sda_prev &  r_sda_sync;
    assign sda_s     =  r_sda_sync;

endmodule

// File: rtl/i2c_module.sv
// I2C slave bridging an external master to a 16-bit register file:
// decodes device/register/data bytes, issues one-cycle req strobes and serializes reads.
module i2c_module
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        SCL,
    input  logic        iSDA,
    output logic        oSDA,
    output logic [7:0]  ADDR,
    output logic [15:0] WR_DATA,
    input  logic [15:0] RD_DATA,
    output logic        RNW,
    output logic        req,
    output logic        goodCRC
);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start_det;
    logic w_stop_det;
    logic w_sda_s;

    i2c_state_t  r_state;
    i2c_state_t  w_next_state;

    logic [7:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_lsb;
    logic [7:0]  r_tx;
    logic [15:0] r_rd_data;
    logic        r_rd_pend;
    logic        r_mack;
    logic        r_osda;
    logic [7:0]  r_addr;
    logic [15:0] r_wr_data;
    logic        r_rnw;
    logic        r_req;
    logic        r_good;

    logic        w_byte_done;
    logic        w_addr_match;
    logic        w_read_sel;

    i2c_bus_sync u_bus_sync (
        .CLK       (CLK),
        .Reset     (Reset),
        .SCL       (SCL),
        .iSDA      (iSDA),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start_det),
        .stop_det  (w_stop_det),
        .sda_s     (w_sda_s)
    );

    assign w_byte_done  = (r_bit_cnt == 4'd8);
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);
    assign w_read_sel   = r_shift[0];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A byte is complete on the falling SCL edge after its 8th rising edge;
    // each ACK slot is left on the falling edge that ends it.
    always_comb begin
        // NOTE: hold-current default first so no path through the case infers a latch.
        w_next_state = r_state;
        if (w_stop_det) begin
            w_next_state = ST_IDLE;
        end else if (w_start_det) begin
            w_next_state = ST_DEV_ADDR;
        end else begin
            case (r_state)
                ST_IDLE:      w_next_state = ST_IDLE;
                ST_DEV_ADDR:  if (w_scl_fall && w_byte_done)
                                  w_next_state = w_addr_match ? ST_ACK_DEV : ST_WAIT_STOP;
                ST_ACK_DEV:   if (w_scl_fall)
                                  w_next_state = w_read_sel ? ST_RD_LSB : ST_REG_ADDR;
                ST_REG_ADDR:  if (w_scl_fall && w_byte_done) w_next_state = ST_ACK_REG;
                ST_ACK_REG:   if (w_scl_fall) w_next_state = ST_WR_LSB;
                ST_WR_LSB:    if (w_scl_fall && w_byte_done) w_next_state = ST_ACK_LSB;
                ST_ACK_LSB:   if (w_scl_fall) w_next_state = ST_WR_MSB;
                ST_WR_MSB:    if (w_scl_fall && w_byte_done) w_next_state = ST_ACK_MSB;
                ST_ACK_MSB:   if (w_scl_fall) w_next_state = ST_WAIT_STOP;
                ST_RD_LSB:    if (w_scl_fall && w_byte_done) w_next_state = ST_MACK_LSB;
                ST_MACK_LSB:  if (w_scl_fall)
                                  w_next_state = (r_mack == ACK) ? ST_RD_MSB : ST_WAIT_STOP;
                ST_RD_MSB:    if (w_scl_fall && w_byte_done) w_next_state = ST_MACK_MSB;
                ST_MACK_MSB:  if (w_scl_fall) w_next_state = ST_WAIT_STOP;
                ST_WAIT_STOP: w_next_state = ST_WAIT_STOP;
                default:      w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_lsb     <= '0;
            r_tx      <= '0;
            r_rd_data <= '0;
            r_rd_pend <= 1'b0;
            r_mack    <= NACK;
            r_osda    <= NACK;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rnw     <= 1'b1;
            r_req     <= 1'b0;
            r_good    <= 1'b0;
        end else begin
            r_req     <= 1'b0;
            r_good    <= 1'b0;
            // Register-file read data is captured two cycles after a read req.
            r_rd_pend <= r_req & r_rnw;
            if (r_rd_pend) begin
                r_rd_data <= RD_DATA;
            end

            if (w_stop_det || w_start_det) begin
                r_bit_cnt <= '0;
                r_osda    <= NACK;
            end else if (is_rx_state(r_state)) begin
                if (w_scl_rise) begin
                    r_shift   <= {r_shift[6:0], w_sda_s};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (w_scl_fall && w_byte_done) begin
                    r_bit_cnt <= '0;
                    r_osda    <= (r_state == ST_DEV_ADDR && !w_addr_match) ? NACK : ACK;
                    if (r_state == ST_REG_ADDR) r_addr <= r_shift;
                    if (r_state == ST_WR_LSB)   r_lsb  <= r_shift;
                end
            end else begin
                case (r_state)
                    ST_ACK_DEV: begin
                        if (w_scl_rise && w_read_sel) begin
                            r_rnw <= 1'b1;
                            r_req <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (w_read_sel) begin
                                r_osda <= r_rd_data[7];
                                r_tx   <= {r_rd_data[6:0], 1'b0};
                            end else begin
                                r_osda <= NACK;
                            end
                        end
                    end
                    ST_ACK_REG, ST_ACK_LSB: begin
                        if (w_scl_fall) r_osda <= NACK;
                    end
                    ST_ACK_MSB: begin
                        if (w_scl_rise) begin
                            r_wr_data <= {r_shift, r_lsb};
                            r_rnw     <= 1'b0;
                            r_req     <= 1'b1;
                            r_good    <= 1'b1;
                        end else if (w_scl_fall) begin
                            r_osda <= NACK;
                        end
                    end
                    ST_RD_LSB, ST_RD_MSB: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (w_byte_done) begin
                                r_bit_cnt <= '0;
                                r_osda    <= NACK;
                            end else begin
                                r_osda <= r_tx[7];
                                r_tx   <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    ST_MACK_LSB: begin
                        if (w_scl_rise) begin
                            r_mack <= w_sda_s;
                        end else if (w_scl_fall && r_mack == ACK) begin
                            r_osda <= r_rd_data[15];
                            r_tx   <= {r_rd_data[14:8], 1'b0};
                        end
                    end
                    ST_MACK_MSB: begin
                        if (w_scl_rise && w_sda_s == NACK) r_good <= 1'b1;
                    end
                    default: begin
                        r_bit_cnt <= '0;
                        r_osda    <= NACK;
                    end
                endcase
            end
        end
    end

    assign oSDA    = r_osda;
    assign ADDR    = r_addr;
    assign WR_DATA = r_wr_data;
    assign RNW     = r_rnw;
    assign req     = r_req;
    assign goodCRC = r_good;

endmodule

// File: tb/tb_i2c_module.sv
// Directed bench for i2c_module: a bit-banged I2C master, a small register-file
// model and pulse monitors; expected values are hand-computed constants.
module tb_i2c_module;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        oSDA;
    logic        iSDA;
    logic [7:0]  ADDR;
    logic [15:0] WR_DATA;
    logic [15:0] RD_DATA;
    logic        RNW;
    logic        req;
    logic        goodCRC;

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    int          req_cnt  = 0;
    int          good_cnt = 0;
    int          low_cnt  = 0;
    logic        last_rnw;
    logic [7:0]  last_addr;
    logic [15:0] last_wdata;

    always #5 CLK = ~CLK;

    assign iSDA    = m_sda & oSDA;
    assign RD_DATA = mem[ADDR];

    i2c_module #(.SLAVE_ADDR(7'h50)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .SCL     (m_scl),
        .iSDA    (iSDA),
        .oSDA    (oSDA),
        .ADDR    (ADDR),
        .WR_DATA (WR_DATA),
        .RD_DATA (RD_DATA),
        .RNW     (RNW),
        .req     (req),
        .goodCRC (goodCRC)
    );

    always @(posedge CLK) begin
        if (req) begin
            req_cnt    <= req_cnt + 1;
            last_rnw   <= RNW;
            last_addr  <= ADDR;
            last_wdata <= WR_DATA;
            if (!RNW) mem[ADDR] <= WR_DATA;
        end
        if (goodCRC) good_cnt <= good_cnt + 1;
        if (!oSDA)   low_cnt  <= low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; clk_wait(4);
        m_scl = 1'b1; clk_wait(8);
        m_sda = 1'b0; clk_wait(8);
        m_scl = 1'b0; clk_wait(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; clk_wait(4);
        m_scl = 1'b1; clk_wait(8);
        m_sda = 1'b1; clk_wait(8);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    clk_wait(4);
        m_scl = 1'b1; clk_wait(8);
        m_scl = 1'b0; clk_wait(4);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; clk_wait(4);
        m_scl = 1'b1; clk_wait(4);
        ack = iSDA;   clk_wait(4);
        m_scl = 1'b0; clk_wait(4);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            clk_wait(4);
            m_scl = 1'b1; clk_wait(4);
            b[i] = iSDA;  clk_wait(4);
            m_scl = 1'b0; clk_wait(4);
        end
        send_bit(mack);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge CLK);
        check({tag, ".oSDA"},    oSDA,    1'b1);
        check({tag, ".ADDR"},    ADDR,    8'h00);
        check({tag, ".WR_DATA"}, WR_DATA, 16'h0000);
        check({tag, ".RNW"},     RNW,     1'b1);
        check({tag, ".req"},     req,     1'b0);
        check({tag, ".goodCRC"}, goodCRC, 1'b0);
    endtask

    // Full register write; checks every ACK and the resulting req.
    task automatic do_write(input string tag, input logic [7:0] ra, input logic [15:0] d);
        logic a;
        int   r0, g0;
        r0 = req_cnt; g0 = good_cnt;
        i2c_start();
        write_byte(8'hA0,   a); check({tag, ".ack_dev"}, a, 1'b0);
        write_byte(ra,      a); check({tag, ".ack_reg"}, a, 1'b0);
        write_byte(d[7:0],  a); check({tag, ".ack_lsb"}, a, 1'b0);
        write_byte(d[15:8], a); check({tag, ".ack_msb"}, a, 1'b0);
        i2c_stop();
        check({tag, ".req_cnt"},  req_cnt - r0, 1);
        check({tag, ".rnw"},      last_rnw,     1'b0);
        check({tag, ".addr"},     last_addr,    ra);
        check({tag, ".wdata"},    last_wdata,   d);
        check({tag, ".good_cnt"}, good_cnt - g0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] b;
        int         r0, g0, l0;

        clk_wait(5);
        check_reset_outputs("por");
        Reset = 1'b1;
        clk_wait(10);

        do_write("wr", 8'h05, 16'h1234);
        check("wr.ADDR_port",    ADDR,    8'h05);
        check("wr.WR_DATA_port", WR_DATA, 16'h1234);

        // Read back register 0x05 through a repeated START.
        r0 = req_cnt; g0 = good_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("rd.ack_dev_w", a, 1'b0);
        write_byte(8'h05, a); check("rd.ack_reg",   a, 1'b0);
        i2c_start();
        write_byte(8'hA1, a); check("rd.ack_dev_r", a, 1'b0);
        read_byte(1'b0, b);   check("rd.lsb", b, 8'h34);
        read_byte(1'b1, b);   check("rd.msb", b, 8'h12);
        i2c_stop();
        check("rd.req_cnt",  req_cnt - r0,  1);
        check("rd.rnw",      last_rnw,      1'b1);
        check("rd.addr",     last_addr,     8'h05);
        check("rd.good_cnt", good_cnt - g0, 1);

        // Foreign device address: no ACK, bytes ignored until STOP.
        r0 = req_cnt; g0 = good_cnt; l0 = low_cnt;
        i2c_start();
        write_byte(8'hB0, a); check("bad.ack_dev", a, 1'b1);
        write_byte(8'h05, a); check("bad.ack_2",   a, 1'b1);
        write_byte(8'h00, a); check("bad.ack_3",   a, 1'b1);
        i2c_stop();
        check("bad.req_cnt",  req_cnt - r0,  0);
        check("bad.good_cnt", good_cnt - g0, 0);
        check("bad.osda_low", low_cnt - l0,  0);

        // Overrun: third data byte is NACKed, only one req.
        r0 = req_cnt; g0 = good_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("ovr.ack_dev", a, 1'b0);
        write_byte(8'h07, a); check("ovr.ack_reg", a, 1'b0);
        write_byte(8'h78, a); check("ovr.ack_lsb", a, 1'b0);
        write_byte(8'h56, a); check("ovr.ack_msb", a, 1'b0);
        write_byte(8'h9A, a); check("ovr.ack_extra", a, 1'b1);
        i2c_stop();
        check("ovr.req_cnt",  req_cnt - r0,  1);
        check("ovr.addr",     last_addr,     8'h07);
        check("ovr.wdata",    last_wdata,    16'h5678);
        check("ovr.good_cnt", good_cnt - g0, 1);

        // Early abort after the register byte, then a normal write.
        r0 = req_cnt; g0 = good_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("abt.ack_dev", a, 1'b0);
        write_byte(8'h09, a); check("abt.ack_reg", a, 1'b0);
        i2c_stop();
        check("abt.req_cnt",  req_cnt - r0,  0);
        check("abt.good_cnt", good_cnt - g0, 0);
        check("abt.state",    dut.r_state == i2c_pkg::ST_IDLE, 1'b1);
        do_write("abt_next", 8'h0A, 16'hABCD);

        // Reset in the middle of the register byte.
        r0 = req_cnt; g0 = good_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("rst.ack_dev", a, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        Reset = 1'b0;
        clk_wait(2);
        m_scl = 1'b1;
        m_sda = 1'b1;
        check_reset_outputs("rst");
        clk_wait(4);
        Reset = 1'b1;
        clk_wait(10);
        check("rst.req_cnt",  req_cnt - r0,  0);
        check("rst.good_cnt", good_cnt - g0, 0);
        do_write("rst_next", 8'h22, 16'hBEEF);

        clk_wait(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_module.md
# i2c_module

I2C slave front-end that bridges an external I2C master to the on-chip 16-bit register file (`Registros`). It oversamples SCL/SDA with the system clock. It decodes device address, register address and data bytes, and drives a single-cycle register request (`req`, `ADDR`, `RNW`, `WR_DATA`). On reads it returns `RD_DATA` serially over `oSDA`.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit device address the block responds to.
- `CLK` input, 1 bit: system clock. Every flop in the block uses this clock.
- `Reset` input, 1 bit: asynchronous, active-low reset.
- `SCL` input, 1 bit: I2C clock from the master (asynchronous to `CLK`).
- `iSDA` input, 1 bit: I2C data as seen on the bus.
- `oSDA` output, 1 bit: open-drain data drive. 0 pulls the line low; 1 releases it.
- `ADDR` output, 8 bits: register address presented to the register file.
- `WR_DATA` output, 16 bits: write data presented to the register file.
- `RD_DATA` input, 16 bits: read data returned by the register file.
- `RNW` output, 1 bit: 1 means read, 0 means write. Qualified by `req`.
- `req` output, 1 bit: one-cycle register access strobe.
- `goodCRC` output, 1 bit: one-cycle pulse when a transaction completes with every byte acknowledged as required.

## Operation
- `SCL` and `iSDA` pass through 2-flop synchronizers. Edges are then detected in the `CLK` domain.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge, MSB first.
- A START in any state (including a repeated START) goes to DEV_ADDR. A STOP in any state goes to IDLE.
- States:
  - IDLE
  - DEV_ADDR, ACK_DEV
  - REG_ADDR, ACK_REG
  - WR_LSB, ACK_LSB, WR_MSB, ACK_MSB
  - RD_LSB, MACK_LSB, RD_MSB, MACK_MSB
  - WAIT_STOP
- DEV_ADDR: shift in 8 bits.
  - If bits[7:1] ≠ SLAVE_ADDR: leave `oSDA`=1 (NACK) and go to WAIT_STOP.
  - If they match: ACK. Bit0=0 selects the write path (REG_ADDR); bit0=1 selects the read path.
- Write path:
  - The register byte is ACKed and loaded into `ADDR`.
  - Then LSB, then MSB; each is ACKed.
  - After the MSB ACK: `WR_DATA={MSB,LSB}`, `RNW`=0, and `req` and `goodCRC` pulse together. Next state is WAIT_STOP.
  - Any further byte is NACKed.
- Read path:
  - On the address+R ACK: `RNW`=1 and `req` pulses, using the current `ADDR` (the last register byte received).
  - `RD_DATA` is latched 2 CLK after `req`.
  - LSB is sent, then MSB.
  - A master ACK after LSB continues to MSB. A master NACK after LSB goes to WAIT_STOP without `goodCRC`.
  - A master NACK after MSB pulses `goodCRC`.
- A master that sends no register byte before a read gets the previously held `ADDR`.

## Timing
- Reset values: `oSDA`=1, `ADDR`=0, `WR_DATA`=0, `RNW`=1, `req`=0, `goodCRC`=0, state IDLE.
- Reset mid-transfer aborts immediately with no `req`.
- SCL high and low phases must each be ≥4 CLK periods. Synchronizer latency is 2 CLK; edge detect adds 1 CLK.
- `oSDA` updates 1 CLK after a detected SCL falling edge and holds until the next falling edge. The ACK drive is released on the falling edge that ends the ACK bit.
- `req` is exactly 1 CLK wide. Write `req` asserts 1 CLK after the SCL rising edge that samples the MSB ACK slot. `ADDR`, `WR_DATA` and `RNW` are stable in the `req` cycle and hold until the next access.
- `goodCRC` is exactly 1 CLK wide.
- If START and STOP conditions coincide with a data edge, START/STOP take priority.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum;
  - the default SLAVE_ADDR;
  - the constants ACK=0 and NACK=1.
- One sub-module, `i2c_bus_sync`: 2-flop synchronizers plus outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
- The FSM and shift registers stay in the top level.

## Test plan
- Reset: assert `Reset`=0 mid-byte. Required: all outputs at their reset values, no `req`; the next START works normally.
- Write: START, 0xA0, 0x05, 0x34, 0x12, STOP. Required: 4 ACKs; one `req` with `RNW`=0, `ADDR`=0x05, `WR_DATA`=0x1234; `goodCRC` pulse.
- Read: write register 0x05 = 0x1234, then START, 0xA0, 0x05, repeated START, 0xA1. Required: `req` with `RNW`=1, `ADDR`=0x05; bits 0x34 then 0x12 on `oSDA`; master ACK then NACK; `goodCRC` pulse.
- Wrong address: 0xB0. Required: NACK (`oSDA` stays 1), no `req`, block ignores bytes until STOP.
- Overrun: write with a third data byte. Required: that byte is NACKed, exactly one `req`.
- Early abort: STOP after the register byte. Required: IDLE, no `req`, no `goodCRC`; the subsequent transaction succeeds.
